// File: rtl/sram_1rw_ctrl_pkg.sv
// Shared types and defaults for the single-port 1RW SRAM controller.
package sram_1rw_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;

    // TA only exists when SRAM_1RW_CTRL_TURNAROUND_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_TA   = 2'd3
    } state_e;

    // Active-low SRAM strobes as they appear on the pins.
    typedef struct packed {
        logic csb;
        logic web;
        logic oeb;
    } strobes_t;

    // Strobe pattern the macro must see while the FSM sits in a given state.
    function automatic strobes_t strobes_for(input state_e s);
        strobes_t st;
        case (s)
            ST_WR:   st = '{csb: 1'b0, web: 1'b0, oeb: 1'b1};
            ST_RD:   st = '{csb: 1'b0, web: 1'b1, oeb: 1'b0};
            default: st = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sram_1rw_ctrl.sv
// Synchronous initiator for a single-port 1RW OpenRAM macro.
// Sequences CSb/WEb/OEb, drives DATA only during writes and captures read
// data RD_LATENCY cycles after the macro's read edge into a one-entry
// response slot. A read whose response slot is still occupied keeps
// re-reading the same word until the slot frees up.
// Optional feature: define SRAM_1RW_CTRL_TURNAROUND_EN to insert one
// all-strobes-high turnaround cycle after every read capture.
module sram_1rw_ctrl
    import sram_1rw_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = 1   // must be >= 1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  CSb,
    output logic                  WEb,
    output logic                  OEb,
    inout  wire  [DATA_WIDTH-1:0] DATA
);

    localparam int CNT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    strobes_t              strb_d;
    logic                  csb_q, web_q, oeb_q;
    logic                  data_oe_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic slot_free;
    logic rd_last;
    logic capture;
    logic accept;

    // Capture happens on the last RD edge, but only into a free response slot.
    always_comb begin
        slot_free = !rsp_valid_q || rsp_ready;
        rd_last   = (state_q == ST_RD) && (cnt_q == '0);
        capture   = rd_last && slot_free;
        accept    = req_valid && req_ready;
    end

    // Request acceptance: open in IDLE/WR, and on the capture cycle unless a turnaround follows.
    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_WR: req_ready = 1'b1;
`ifdef SRAM_1RW_CTRL_TURNAROUND_EN
            ST_RD:          req_ready = 1'b0;
`else
            ST_RD:          req_ready = capture;
`endif
            default:        req_ready = 1'b0;
        endcase
    end

    // State and read-latency counter register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: RD counts down, then waits for the response slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_WR: begin
                if (accept) begin
                    state_d = req_we ? ST_WR : ST_RD;
                    cnt_d   = RD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (slot_free) begin
`ifdef SRAM_1RW_CTRL_TURNAROUND_EN
                    state_d = ST_TA;
`else
                    if (accept) begin
                        state_d = req_we ? ST_WR : ST_RD;
                        cnt_d   = RD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes for the upcoming cycle are decoded from the next state.
    always_comb begin
        strb_d = strobes_for(state_d);
    end

    // Strobe and DATA output-enable registers feeding the macro pins.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            oeb_q     <= 1'b1;
            data_oe_q <= 1'b0;
        end else begin
            csb_q     <= strb_d.csb;
            web_q     <= strb_d.web;
            oeb_q     <= strb_d.oeb;
            data_oe_q <= (state_d == ST_WR);
        end
    end

    // Address and write data are latched only on acceptance, so a stalled read keeps its address.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            if (req_we) begin
                wdata_q <= req_wdata;
            end
        end
    end

    // Response slot: a capture wins over a same-edge consume.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= DATA;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign DATA      = data_oe_q ? wdata_q : 'z;
    assign ADDR      = addr_q;
    assign CSb       = csb_q;
    assign WEb       = web_q;
    assign OEb       = oeb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/sram_1rw_ctrl.md
# sram_1rw_ctrl

Synchronous initiator for the single-port 1RW OpenRAM SRAM macros (DATA/ADDR/CSb/WEb/OEb/clk interface). It accepts word read/write requests from a core over a valid/ready handshake. It sequences the SRAM strobes, drives the bidirectional DATA bus only during writes, and samples read data after the macro's output delay. It returns read data over a valid/ready response channel. It sits between the core-side memory port and one SRAM bank.

## Interface
- DATA_WIDTH, 32, word width; must equal the macro's word size
- ADDR_WIDTH, 9, word address width; 512 words by default
- RD_LATENCY, 1, extra cycles after the SRAM read edge before DATA is sampled; must be ≥1
- clk  input  1  clock; the SRAM macro shares it
- rstb  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted on the clk edge where req_valid && req_ready
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  read data available
- rsp_ready  input  1  consumer takes rsp_rdata
- rsp_rdata  output  DATA_WIDTH  read data
- ADDR  output  ADDR_WIDTH  to SRAM
- CSb, WEb, OEb  output  1 each  active-low SRAM strobes
- DATA  inout  DATA_WIDTH  SRAM data bus

## Operation
- Strobe, ADDR and write-data registers are updated on posedge clk. The SRAM samples them on the following edge.
- The DATA output enable is a register. The controller drives DATA only while CSb=0 and WEb=0. Otherwise it presents high-Z.
- FSM states:
  - IDLE: CSb=WEb=OEb=1.
  - WR: CSb=0, WEb=0, OEb=1; DATA driven with wdata. Occupies exactly one cycle per write.
  - RD: CSb=0, WEb=1, OEb=0. Occupies 1+RD_LATENCY cycles, counted by a down-counter.
  - TA: all strobes high. Present only with the macro enabled.
- req_ready is 1 in IDLE and WR, and 1 in the final RD cycle when the capture will occur. It is 0 otherwise.
- Back-to-back writes issue one per cycle with CSb held low.
- Read capture happens at the last RD edge: rsp_rdata <= DATA and rsp_valid <= 1.
- If rsp_valid && !rsp_ready at the capture edge, the read stalls:
  - RD holds with CSb/OEb low and ADDR unchanged, so the SRAM re-reads the same word.
  - Capture occurs on the first edge where the slot is free.
  - req_ready stays 0 during the stall.
- rsp_valid clears on rsp_valid && rsp_ready, unless a new capture occurs on the same edge. In that case it stays 1 with the new data.
- Writes produce no response.
- A write request accepted while a response is pending proceeds normally. Only read capture waits on the response slot.

## Timing
- Reset (rstb=0, asynchronous): state=IDLE, CSb=WEb=OEb=1, ADDR=0, DATA high-Z, rsp_valid=0, rsp_rdata=0, req_ready=1 after release.
- Write:
  - Accept at edge 0.
  - WR is active during cycle 0–1.
  - The SRAM writes at edge 1.
- Read, RD_LATENCY=1:
  - Accept at edge 0.
  - The SRAM reads at edge 1; its data is valid by DELAY after edge 1.
  - Capture at edge 2; rsp_valid high in cycle 2.
  - Accept-to-response latency is 1+RD_LATENCY cycles.
- Reset mid-read: the read is aborted, no response is produced, and DATA returns to high-Z immediately.
- Address wrap: none; ADDR is taken verbatim from req_addr.

## Configuration
- SRAM_1RW_CTRL_TURNAROUND_EN:
  - Defined: after every read capture, the FSM enters TA for one cycle, with all strobes high and DATA high-Z, before it can accept a request. req_ready is 0 in the final RD cycle and in TA.
  - Undefined: there is no TA state. A request can be accepted on the capture edge, and a following write drives DATA in the next cycle.

## Structure
- Package sram_1rw_ctrl_pkg: FSM state enum (IDLE, WR, RD, TA) and the default DATA_WIDTH/ADDR_WIDTH constants.
- No sub-module; the tri-state assign and response register stay in the top module.

## Test plan
- After reset, check CSb=WEb=OEb=1, DATA=Z, rsp_valid=0 and req_ready=1. Then write 0xDEADBEEF to 0x005 and read 0x005 → rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after the read is accepted.
- Write 0x1/0x2/0x3 to addresses 0x000/0x001/0x1FF on consecutive cycles → CSb low for 3 consecutive cycles, WEb low for all three, and all three read back correctly.
- Read 0x1FF with rsp_ready=0 for 4 cycles while rsp_valid is held from a prior read → CSb/OEb remain low, the second capture is delayed, and each data word is delivered once and in order.
- Issue a read immediately followed by a write:
  - With SRAM_1RW_CTRL_TURNAROUND_EN: one all-strobes-high cycle between the two accesses.
  - Without the macro: the write's CSb-low cycle directly follows the read.
  - In both cases: no cycle where the controller drives DATA while WEb=1.
- Assert rstb=0 in cycle 1 of a read → strobes go high asynchronously, rsp_valid never rises, and the next read after release returns correct data.
